// File: rtl/period_meter.sv
// rtl/period_meter.sv - period measurement of a slow asynchronous square wave in clkin cycles
module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000000
) (
    input  logic             clkin,
    input  logic             clr_n,
    input  logic             sig_in,
    input  logic             meas_en,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             overrun,
    output logic             stalled
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_d;
    logic             valid_d, overrun_d, stalled_d;
    logic             s1, s2, s3;
    logic             rise;
    logic             timeout;

    // s1/s2 resolve metastability; s3 only delays s2 for edge detection
    assign rise    = s2 & ~s3;
    assign timeout = (cnt_q == TO_VAL);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period;
        valid_d   = period_valid;
        overrun_d = overrun;
        stalled_d = stalled;

        if (rd_ack && period_valid) begin
            valid_d = 1'b0;
        end

        if (state_q != S_IDLE && !meas_en) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            overrun_d = 1'b0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    stalled_d = 1'b0;
                    if (meas_en) begin
                        state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_MEAS;
                    end else if (timeout) begin
                        stalled_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        // a simultaneous rd_ack consumes the old result, so the new one is not an overrun
                        if (period_valid && !rd_ack) begin
                            overrun_d = 1'b1;
                        end
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        stalled_d = 1'b0;
                        cnt_d     = CNT_ONE;
                    end else if (timeout) begin
                        stalled_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (!clr_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1           <= sig_in;
            s2           <= s1;
            s3           <= s2;
            period       <= period_d;
            period_valid <= valid_d;
            overrun      <= overrun_d;
            stalled      <= stalled_d;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
module tb_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;

    logic             clkin = 1'b0;
    logic             clr_n = 1'b0;
    logic             sig_in = 1'b0;
    logic             meas_en = 1'b0;
    logic             rd_ack = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             overrun;
    logic             stalled;

    period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clkin       (clkin),
        .clr_n       (clr_n),
        .sig_in      (sig_in),
        .meas_en     (meas_en),
        .rd_ack      (rd_ack),
        .period      (period),
        .period_valid(period_valid),
        .overrun     (overrun),
        .stalled     (stalled)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int hi;
        int lo;
        int nper;
        bit ack;
        int exp_period;
        bit exp_ovr;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit wave_on = 1'b0;
    bit sig_drv = 1'b0;
    bit ack_drv = 1'b0;
    bit mon_en = 1'b0;
    int hi_len = 1;
    int lo_len = 1;
    int ph = 0;
    int last_rise = -1;
    int cyc = 0;
    int row_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive inputs 1 time unit after posedge, sample outputs on negedge
    task automatic tick();
        int e;
        @(posedge clkin);
        #1;
        if (wave_on) begin
            ph = (ph + 1) % (hi_len + lo_len);
            if (ph < hi_len && !sig_drv) begin
                if (last_rise >= 0 && mon_en) exp_q.push_back(cyc - last_rise);
                last_rise = cyc;
            end
            sig_drv = (ph < hi_len);
        end
        sig_in  = sig_drv;
        rd_ack  = ack_drv;
        ack_drv = 1'b0;
        cyc++;
        @(negedge clkin);
        if (mon_en && period_valid && !rd_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got result %0d, expected no result", period);
            end else begin
                e = exp_q.pop_front();
                chk("sb_period", 32'(period), e);
                chk("row_period", 32'(period), row_exp);
            end
            ack_drv = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        clr_n   = 1'b0;
        meas_en = 1'b0;
        wave_on = 1'b0;
        mon_en  = 1'b0;
        sig_drv = 1'b0;
        ack_drv = 1'b0;
        exp_q.delete();
        run(2);
        clr_n     = 1'b1;
        last_rise = -1;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_valid"}, 32'(period_valid), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_stalled"}, 32'(stalled), 0);
    endtask

    initial begin
        vecs[0] = '{hi: 5, lo: 5, nper: 6, ack: 1'b1, exp_period: 10, exp_ovr: 1'b0};
        vecs[1] = '{hi: 3, lo: 4, nper: 6, ack: 1'b1, exp_period: 7,  exp_ovr: 1'b0};
        vecs[2] = '{hi: 2, lo: 2, nper: 8, ack: 1'b1, exp_period: 4,  exp_ovr: 1'b0};
        vecs[3] = '{hi: 9, lo: 4, nper: 5, ack: 1'b1, exp_period: 13, exp_ovr: 1'b0};
        vecs[4] = '{hi: 5, lo: 5, nper: 4, ack: 1'b0, exp_period: 10, exp_ovr: 1'b1};

        // reset state
        run(2);
        chk_zero("reset");
        clr_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            meas_en = 1'b1;
            run(2);
            hi_len  = vecs[i].hi;
            lo_len  = vecs[i].lo;
            ph      = vecs[i].hi;
            row_exp = vecs[i].exp_period;
            mon_en  = vecs[i].ack;
            wave_on = 1'b1;
            run(vecs[i].nper * (vecs[i].hi + vecs[i].lo));
            wave_on = 1'b0;
            sig_drv = 1'b0;
            run(8);
            chk("row_overrun", 32'(overrun), 32'(vecs[i].exp_ovr));
            if (vecs[i].ack) begin
                chk("row_sb_drained", exp_q.size(), 0);
            end else begin
                chk("noack_period", 32'(period), vecs[i].exp_period);
                chk("noack_valid", 32'(period_valid), 1);
                meas_en = 1'b0;
                run(2);
                chk("dis_overrun", 32'(overrun), 0);
                chk("dis_valid_kept", 32'(period_valid), 1);
                chk("dis_period_kept", 32'(period), vecs[i].exp_period);
            end
            mon_en = 1'b0;
        end

        // rd_ack on the exact capture cycle
        do_reset();
        meas_en = 1'b1;
        run(3);
        sig_drv = 1'b1; run(5);
        sig_drv = 1'b0; run(5);
        sig_drv = 1'b1; run(5);
        sig_drv = 1'b0; run(3);
        chk("pre_ack_valid", 32'(period_valid), 1);
        chk("pre_ack_period", 32'(period), 10);
        sig_drv = 1'b1;
        tick();
        tick();
        ack_drv = 1'b1;
        tick();
        tick();
        chk("simul_valid", 32'(period_valid), 1);
        chk("simul_period", 32'(period), 8);
        chk("simul_overrun", 32'(overrun), 0);
        tick();
        chk("simul_valid_hold", 32'(period_valid), 1);

        // reset mid-measurement with a pending result
        sig_drv = 1'b0;
        clr_n   = 1'b0;
        tick();
        chk_zero("midreset");
        clr_n = 1'b1;
        tick();
        sig_drv = 1'b1; run(5);
        sig_drv = 1'b0; run(5);
        chk("one_rise_valid", 32'(period_valid), 0);
        chk("one_rise_period", 32'(period), 0);
        sig_drv = 1'b1; run(5);
        chk("two_rise_valid", 32'(period_valid), 1);
        chk("two_rise_period", 32'(period), 10);

        // timeout: signal stops after a capture, then resumes
        do_reset();
        meas_en = 1'b1;
        run(3);
        sig_drv = 1'b1; run(5);
        sig_drv = 1'b0; run(5);
        sig_drv = 1'b1; tick();
        run(4);
        chk("to_period", 32'(period), 10);
        sig_drv = 1'b0;
        run(48);
        chk("to_not_yet", 32'(stalled), 0);
        tick();
        chk("to_stalled", 32'(stalled), 1);
        sig_drv = 1'b1; run(5);
        sig_drv = 1'b0; run(5);
        chk("resume_arm_stalled", 32'(stalled), 1);
        sig_drv = 1'b1; run(5);
        chk("resume_cleared", 32'(stalled), 0);
        chk("resume_period", 32'(period), 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
